// File: rtl/tile_sched_controller.sv
// Job-level sequencer for the conv datapath: walks num_w_tiles weight tiles x num_if_tiles
// ifmap tiles, prefetching weight tile k+1 into the shadow buffer while tile k convolves.
module tile_sched_controller #(
  parameter int NW_W  = 8,
  parameter int NIF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NW_W-1:0]  num_w_tiles,
  input  logic [NIF_W-1:0] num_if_tiles,
  input  logic             w_done,
  input  logic             if_done,
  output logic             w_read,
  output logic             if_read,
  output logic             clr_w,
  output logic             clr_if,
  output logic             switch,
  output logic             ready,
  output logic             busy,
  output logic             job_done,
  output logic [NW_W-1:0]  w_tile_idx,
  output logic [NIF_W-1:0] if_tile_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SWITCH = 3'd2;
  localparam logic [2:0] S_CONV   = 3'd3;
  localparam logic [2:0] S_WAIT_W = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [NW_W-1:0]  num_w_q, num_w_d;
  logic [NIF_W-1:0] num_if_q, num_if_d;
  logic [NW_W-1:0]  w_idx_q, w_idx_d;
  logic [NIF_W-1:0] if_idx_q, if_idx_d;
  logic             first_q, first_d;
  logic             pf_q, pf_d;

  logic [NW_W-1:0]  w_next_idx;
  logic             more_w;
  logic             last_if;

  // Comparisons are one bit wider so a count of 2^N-1 never wraps.
  assign w_next_idx = first_q ? '0 : w_idx_q + NW_W'(1);
  assign more_w     = ({1'b0, w_next_idx} + (NW_W+1)'(1)) < {1'b0, num_w_q};
  assign last_if    = ({1'b0, if_idx_q} + (NIF_W+1)'(1)) >= {1'b0, num_if_q};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    num_w_d  = num_w_q;
    num_if_d = num_if_q;
    w_idx_d  = w_idx_q;
    if_idx_d = if_idx_q;
    first_d  = first_q;
    pf_d     = pf_q;
    w_read   = 1'b0;
    if_read  = 1'b0;
    clr_w    = 1'b0;
    clr_if   = 1'b0;
    switch   = 1'b0;
    job_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_w_d  = num_w_tiles;
          num_if_d = num_if_tiles;
          first_d  = 1'b1;
          if (num_w_tiles == '0 || num_if_tiles == '0) begin
            state_d = S_DONE;
          end else begin
            clr_w   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH, S_WAIT_W: begin
        w_read = ~w_done;
        if (w_done) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        switch   = 1'b1;
        clr_if   = 1'b1;
        w_idx_d  = w_next_idx;
        first_d  = 1'b0;
        if_idx_d = '0;
        pf_d     = more_w;
        clr_w    = more_w;
        state_d  = S_CONV;
      end
      S_CONV: begin
        if_read = ~if_done;
        w_read  = pf_q & ~w_done;
        if (if_done) begin
          if (!last_if) begin
            clr_if   = 1'b1;
            if_idx_d = if_idx_q + NIF_W'(1);
          end else if (!pf_q) begin
            state_d = S_DONE;
          end else if (w_done) begin
            state_d = S_SWITCH;
          end else begin
            state_d = S_WAIT_W;
          end
        end
      end
      S_DONE: begin
        job_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel overrides whatever the state decode above produced.
    if (abort && state_q != S_IDLE) begin
      w_read   = 1'b0;
      if_read  = 1'b0;
      switch   = 1'b0;
      job_done = 1'b0;
      clr_w    = 1'b1;
      clr_if   = 1'b1;
      w_idx_d  = w_idx_q;
      if_idx_d = if_idx_q;
      first_d  = 1'b0;
      pf_d     = 1'b0;
      state_d  = S_IDLE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      num_w_q  <= '0;
      num_if_q <= '0;
      w_idx_q  <= '0;
      if_idx_q <= '0;
      first_q  <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_w_q  <= num_w_d;
      num_if_q <= num_if_d;
      w_idx_q  <= w_idx_d;
      if_idx_q <= if_idx_d;
      first_q  <= first_d;
      pf_q     <= pf_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign w_tile_idx  = w_idx_q;
  assign if_tile_idx = if_idx_q;

endmodule

// File: tb/tb_tile_sched_controller.sv
// Bench for tile_sched_controller: loader/streamer responders with programmable latency,
// a job-level reference model checked every cycle, and hand-computed job milestones.
module tb_tile_sched_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [7:0] num_w, num_if;
  logic       w_done, if_done;
  logic       w_read, if_read, clr_w, clr_if, sw, ready, busy, job_done;
  logic [7:0] w_tile_idx, if_tile_idx;

  tile_sched_controller #(.NW_W(8), .NIF_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_w_tiles(num_w), .num_if_tiles(num_if),
    .w_done(w_done), .if_done(if_done),
    .w_read(w_read), .if_read(if_read), .clr_w(clr_w), .clr_if(clr_if),
    .switch(sw), .ready(ready), .busy(busy), .job_done(job_done),
    .w_tile_idx(w_tile_idx), .if_tile_idx(if_tile_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready, busy, w_read, if_read, clr_w, clr_if, sw, job_done;
    logic [7:0] w_idx, if_idx;
  } out_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is either waiting for weights, swapping, convolving or finishing.
  bit m_busy, m_fin, m_swap, m_conv, m_wpend, m_first;
  int m_nw, m_nif, m_cur_w, m_cur_if;

  function automatic out_t model_out();
    out_t e;
    int   t;
    e = '0;
    e.w_idx  = m_cur_w[7:0];
    e.if_idx = m_cur_if[7:0];
    if (!m_busy) begin
      e.ready = 1'b1;
      if (start) e.clr_w = (num_w != 0 && num_if != 0);
    end else begin
      e.busy = 1'b1;
      if (abort) begin
        e.clr_w  = 1'b1;
        e.clr_if = 1'b1;
      end else if (m_fin) begin
        e.job_done = 1'b1;
      end else if (m_swap) begin
        t = m_first ? 0 : m_cur_w + 1;
        e.sw     = 1'b1;
        e.clr_if = 1'b1;
        e.clr_w  = (t + 1 < m_nw);
      end else if (m_conv) begin
        e.if_read = !if_done;
        e.w_read  = m_wpend && !w_done;
        e.clr_if  = if_done && (m_cur_if + 1 < m_nif);
      end else begin
        e.w_read = !w_done;
      end
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    int t;
    if (!rst) begin
      m_busy = 0; m_fin = 0; m_swap = 0; m_conv = 0; m_wpend = 0; m_first = 0;
      m_nw = 0; m_nif = 0; m_cur_w = 0; m_cur_if = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_nw = num_w; m_nif = num_if; m_first = 1; m_busy = 1;
        m_fin = (m_nw == 0 || m_nif == 0);
        m_wpend = !m_fin;
      end
    end else if (abort) begin
      m_busy = 0; m_fin = 0; m_swap = 0; m_conv = 0; m_wpend = 0; m_first = 0;
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0;
    end else if (m_swap) begin
      t = m_first ? 0 : m_cur_w + 1;
      m_cur_w = t; m_cur_if = 0; m_first = 0;
      m_wpend = (t + 1 < m_nw);
      m_swap = 0; m_conv = 1;
    end else if (m_conv) begin
      if (if_done) begin
        if (m_cur_if + 1 < m_nif) m_cur_if++;
        else begin
          m_conv = 0;
          if (!m_wpend) m_fin = 1;
          else if (w_done) m_swap = 1;
        end
      end
    end else if (w_done) begin
      m_swap = 1;
    end
  end

  always @(negedge clk) begin
    out_t act_o;
    act_o = {ready, busy, w_read, if_read, clr_w, clr_if, sw, job_done, w_tile_idx, if_tile_idx};
    check("cycle_outputs", act_o, model_out());
  end

  // Loader/streamer responders and per-job event log.
  int   w_lat, if_lat, w_cnt, if_cnt;
  int   jc, done_cyc, sw2_cyc, n_sw, n_clrw, n_wrd, n_jd, n_pairs;
  int   pairs [8];
  bit   prev_if_read;
  out_t s;

  task automatic cycle();
    @(negedge clk);
    s = {ready, busy, w_read, if_read, clr_w, clr_if, sw, job_done, w_tile_idx, if_tile_idx};
    if (s.sw) begin
      n_sw++;
      if (n_sw == 2) sw2_cyc = jc;
    end
    if (s.clr_w) n_clrw++;
    if (s.w_read) n_wrd++;
    if (s.job_done) begin
      n_jd++;
      if (done_cyc < 0) done_cyc = jc;
    end
    if (s.if_read && !prev_if_read && n_pairs < 8) begin
      pairs[n_pairs] = int'(s.w_idx) * 256 + int'(s.if_idx);
      n_pairs++;
    end
    prev_if_read = s.if_read;
    jc++;
    @(posedge clk);
    #1;
    if (s.clr_w) begin w_cnt = 0; w_done = 1'b0; end
    else if (s.w_read) begin w_cnt++; if (w_cnt >= w_lat) w_done = 1'b1; end
    if (s.clr_if) begin if_cnt = 0; if_done = 1'b0; end
    else if (s.if_read) begin if_cnt++; if (if_cnt >= if_lat) if_done = 1'b1; end
  endtask

  task automatic run_job(input int nw, input int nif, input int wl, input int il,
                         input int budget, input int abort_at);
    w_lat = wl; if_lat = il;
    jc = 0; done_cyc = -1; sw2_cyc = -1;
    n_sw = 0; n_clrw = 0; n_wrd = 0; n_jd = 0; n_pairs = 0; prev_if_read = 0;
    start = 1'b1; num_w = nw[7:0]; num_if = nif[7:0];
    cycle();
    start = 1'b0;
    while (done_cyc < 0 && jc < budget) begin
      abort = (jc == abort_at);
      cycle();
      if (abort) begin
        abort = 1'b0;
        check("abort_pulses", {s.clr_w, s.clr_if, s.sw, s.job_done}, 4'b1100);
        cycle();
        check("abort_ready_next", s.ready, 1);
        return;
      end
    end
    check("job_done_seen", done_cyc >= 0, 1);
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; num_w = '0; num_if = '0;
    w_done = 1'b0; if_done = 1'b0; w_cnt = 0; if_cnt = 0; w_lat = 1; if_lat = 1;
    #2;
    check("reset_outputs",
          {ready, busy, w_read, if_read, clr_w, clr_if, sw, job_done, w_tile_idx, if_tile_idx},
          24'h80_00_00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cycle();

    // Single tile: w_done in cycle 5, if_done in cycle 12, job_done in cycle 13.
    run_job(1, 1, 4, 5, 100, -1);
    check("t1_done_cycle", done_cyc, 13);
    check("t1_switches", n_sw, 1);
    check("t1_clr_w", n_clrw, 1);
    check("t1_job_done_pulses", n_jd, 1);

    // Three weight tiles of two ifmap tiles each.
    run_job(3, 2, 2, 2, 200, -1);
    check("t2_switches", n_sw, 3);
    check("t2_job_done_pulses", n_jd, 1);
    check("t2_pair_count", n_pairs, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_pair%0d", i), pairs[i], (i / 2) * 256 + (i % 2));

    // Slow prefetch forces a wait for weights before the second swap.
    run_job(2, 1, 10, 2, 200, -1);
    check("t3_done_cycle", done_cyc, 28);
    check("t3_second_switch", sw2_cyc, 24);

    // Prefetch and last ifmap tile finish together: swap next cycle, no wait.
    run_job(2, 1, 3, 3, 200, -1);
    check("t4_second_switch", sw2_cyc, 10);
    check("t4_done_cycle", done_cyc, 15);

    // Abort during conv, then a clean job.
    run_job(2, 2, 2, 4, 200, 7);
    cycle();
    run_job(1, 1, 4, 5, 100, -1);
    check("t5_clean_done_cycle", done_cyc, 13);
    check("t5_clean_switches", n_sw, 1);

    // Empty jobs finish without touching the loader.
    run_job(0, 3, 1, 1, 20, -1);
    check("t6_done_cycle", done_cyc, 1);
    check("t6_w_reads", n_wrd, 0);
    check("t6_clr_w", n_clrw, 0);
    run_job(2, 0, 1, 1, 20, -1);
    check("t6b_done_cycle", done_cyc, 1);
    check("t6b_w_reads", n_wrd, 0);

    // Largest weight-tile count.
    run_job(255, 1, 1, 1, 5000, -1);
    check("t7_switches", n_sw, 255);
    check("t7_last_w_idx", s.w_idx, 254);

    // Asynchronous reset mid-job takes effect without a clock edge.
    start = 1'b1; num_w = 8'd3; num_if = 8'd2; w_lat = 2; if_lat = 2;
    cycle();
    start = 1'b0;
    repeat (7) cycle();
    #2 rst = 1'b0;
    w_done = 1'b0; if_done = 1'b0; w_cnt = 0; if_cnt = 0;
    #1;
    check("rst_async_ready", ready, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_idx", {w_tile_idx, if_tile_idx}, 0);
    cycle();
    rst = 1'b1;
    cycle();
    run_job(1, 1, 4, 5, 100, -1);
    check("t8_after_reset_done_cycle", done_cyc, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
